// File: rtl/filter_mixer.sv
// Voice routing and output mixer around the state-variable filter.
// Ports: clk/iRstN, clkEn strobe, voices, LP/BP/HP, reg bus -> oFiltIn, oOut, oValid.
module filter_mixer #(
  parameter int VOL_SHIFT = 8
) (
  input  logic               clk,
  input  logic               iRstN,
  input  logic               clkEn,
  input  logic signed [15:0] iVoice0,
  input  logic signed [15:0] iVoice1,
  input  logic signed [15:0] iVoice2,
  input  logic signed [15:0] iLP,
  input  logic signed [15:0] iBP,
  input  logic signed [15:0] iHP,
  input  logic               iWE,
  input  logic [4:0]         iAddr,
  input  logic [7:0]         iData,
  output logic signed [15:0] oFiltIn,
  output logic signed [15:0] oOut,
  output logic               oValid
);

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    SCALE,
    SAT
  } state_e;

  state_e state_q;

  logic [2:0] route_q;
  logic       off3_q;
  logic [2:0] mode_q;
  logic [3:0] vol_q;

  logic signed [17:0] dir_q;
  logic signed [17:0] msum_q;
  logic [3:0]         volx_q;
  logic signed [26:0] prod_q;

  logic signed [15:0] filt_q;
  logic signed [15:0] out_q;
  logic               valid_q;

  logic signed [17:0] v0, v1, v2;
  logic signed [17:0] lp, bp, hp;
  logic signed [17:0] filt_d, dir_d, msum_d;
  logic signed [18:0] tot_d;
  logic signed [26:0] tot_x, mul_x, prod_d, shr_d;

  function automatic logic signed [15:0] sat16(input logic signed [26:0] x);
    if (x > 27'sd32767) return 16'sh7FFF;
    else if (x < -27'sd32768) return 16'sh8000;
    else return x[15:0];
  endfunction

  assign v0 = {{2{iVoice0[15]}}, iVoice0};
  assign v1 = {{2{iVoice1[15]}}, iVoice1};
  assign v2 = {{2{iVoice2[15]}}, iVoice2};
  assign lp = {{2{iLP[15]}}, iLP};
  assign bp = {{2{iBP[15]}}, iBP};
  assign hp = {{2{iHP[15]}}, iHP};

  always_comb begin
    filt_d = '0;
    dir_d  = '0;
    msum_d = '0;
    if (route_q[0]) filt_d = filt_d + v0;
    else            dir_d  = dir_d + v0;
    if (route_q[1]) filt_d = filt_d + v1;
    else            dir_d  = dir_d + v1;
    // 3OFF only mutes voice 3 on the direct path
    if (route_q[2]) filt_d = filt_d + v2;
    else if (!off3_q) dir_d = dir_d + v2;
    if (mode_q[0]) msum_d = msum_d + lp;
    if (mode_q[1]) msum_d = msum_d + bp;
    if (mode_q[2]) msum_d = msum_d + hp;
  end

  // {vol,vol} maps 0..15 onto 0..255
  assign tot_d  = {dir_q[17], dir_q} + {msum_q[17], msum_q};
  assign tot_x  = {{8{tot_d[18]}}, tot_d};
  assign mul_x  = {19'd0, volx_q, volx_q};
  assign prod_d = tot_x * mul_x;
  assign shr_d  = prod_q >>> VOL_SHIFT;

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      route_q <= '0;
      off3_q  <= 1'b0;
      mode_q  <= '0;
      vol_q   <= '0;
    end else if (iWE) begin
      if (iAddr == 5'h17) begin
        route_q <= iData[2:0];
      end else if (iAddr == 5'h18) begin
        off3_q <= iData[7];
        mode_q <= iData[6:4];
        vol_q  <= iData[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= IDLE;
      dir_q   <= '0;
      msum_q  <= '0;
      volx_q  <= '0;
      prod_q  <= '0;
      filt_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (clkEn) state_q <= SUM;
        end
        SUM: begin
          dir_q   <= dir_d;
          msum_q  <= msum_d;
          volx_q  <= vol_q;
          filt_q  <= sat16({{9{filt_d[17]}}, filt_d});
          state_q <= SCALE;
        end
        SCALE: begin
          prod_q  <= prod_d;
          state_q <= SAT;
        end
        SAT: begin
          out_q   <= sat16(shr_d);
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oFiltIn = filt_q;
  assign oOut    = out_q;
  assign oValid  = valid_q;

endmodule
